regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport_if.sv | 30 +++
 rtl/regfile_multiport.sv | 89 ++++++++
 tb/tb_regfile_multiport.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// Register-file access bundle: one write port, two read ports, clear request and busy status.
// The master side issues requests; the slave side returns registered read data and Busy.
interface regfile_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              RdEn0;
  logic [ADDR_W-1:0] RdAddr0;
  logic              RdEn1;
  logic [ADDR_W-1:0] RdAddr1;
  logic [DATA_W-1:0] RdData0;
  logic [DATA_W-1:0] RdData1;
  logic              RdValid0;
  logic              RdValid1;
  logic              Clr;
  logic              Busy;

  modport master (
    output WrEn, WrAddr, WrData, RdEn0, RdAddr0, RdEn1, RdAddr1, Clr,
    input  RdData0, RdData1, RdValid0, RdValid1, Busy
  );

  modport slave (
    input  WrEn, WrAddr, WrData, RdEn0, RdAddr0, RdEn1, RdAddr1, Clr,
    output RdData0, RdData1, RdValid0, RdValid1, Busy
  );
endinterface

// File: rtl/regfile_multiport.sv
// 1W/2R register file, 1-cycle registered reads, DEPTH-cycle clear sweep (Busy) after Rst or Clr.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read of the same address.
module regfile_multiport #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int ZERO_REG0 = 0
) (
  input logic             Clk,
  input logic             Rst,
  regfile_multiport_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_take;
  logic              wr_commit;
  logic [DATA_W-1:0] rd_word0;
  logic [DATA_W-1:0] rd_word1;

  // A write coinciding with Clr is dropped; the sweep would erase it anyway.
  assign wr_take   = (state == IDLE) && bus.WrEn && !bus.Clr;
  assign wr_commit = wr_take && !((ZERO_REG0 != 0) && (bus.WrAddr == '0));

  always_comb begin
    rd_word0 = mem[bus.RdAddr0];
    rd_word1 = mem[bus.RdAddr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_take && (bus.RdAddr0 == bus.WrAddr)) rd_word0 = bus.WrData;
    if (wr_take && (bus.RdAddr1 == bus.WrAddr)) rd_word1 = bus.WrData;
`endif
    if ((ZERO_REG0 != 0) && (bus.RdAddr0 == '0)) rd_word0 = '0;
    if ((ZERO_REG0 != 0) && (bus.RdAddr1 == '0)) rd_word1 = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= CLEAR;
      ptr          <= '0;
      bus.RdData0  <= '0;
      bus.RdData1  <= '0;
      bus.RdValid0 <= 1'b0;
      bus.RdValid1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.RdValid0 <= bus.RdEn0;
          bus.RdValid1 <= bus.RdEn1;
          bus.RdData0  <= bus.RdEn0 ? rd_word0 : '0;
          bus.RdData1  <= bus.RdEn1 ? rd_word1 : '0;
          if (bus.Clr) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          bus.RdValid0 <= 1'b0;
          bus.RdValid1 <= 1'b0;
          bus.RdData0  <= '0;
          bus.RdData1  <= '0;
          // Pointer parks on LAST so it never wraps within a sweep.
          if (ptr == LAST) state <= IDLE;
          else             ptr   <= ptr + 1'b1;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign bus.Busy = (state == CLEAR);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else if (wr_commit) mem[bus.WrAddr] <= bus.WrData;
    end
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// Drives a ZERO_REG0=0 and a ZERO_REG0=1 register file with identical stimulus and
// scoreboards both read ports of each against an array-based reference model.
module tb_regfile_multiport;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW)) bus_z ();

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(0)) dut_a (
    .Clk(Clk), .Rst(Rst), .bus(bus_a));
  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG0(1)) dut_z (
    .Clk(Clk), .Rst(Rst), .bus(bus_z));

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } exp_t;

  // Queue index = dut*2 + port; dut 0 is ZERO_REG0=0, dut 1 is ZERO_REG0=1.
  exp_t          exp_q[4][$];
  logic [DW-1:0] m_mem[2][DEPTH];
  int            m_left = 0;
  logic          m_busy = 1'b0;
  int            cyc = 0;
  bit            started = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int d, input logic [AW-1:0] a,
                                             input logic we, input logic clr,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] e;
    e = m_mem[d][a];
`ifdef REGFILE_BYPASS_EN
    if (we && !clr && a == wa) e = wd;
`endif
    if (d == 1 && a == '0) e = '0;
    return e;
  endfunction

  task automatic step(input logic rst, input logic clr, input logic we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re0, input logic [AW-1:0] ra0,
                      input logic re1, input logic [AW-1:0] ra1);
    int   nleft;
    exp_t e;
    Rst = rst;
    bus_a.Clr = clr; bus_a.WrEn = we; bus_a.WrAddr = wa; bus_a.WrData = wd;
    bus_a.RdEn0 = re0; bus_a.RdAddr0 = ra0; bus_a.RdEn1 = re1; bus_a.RdAddr1 = ra1;
    bus_z.Clr = clr; bus_z.WrEn = we; bus_z.WrAddr = wa; bus_z.WrData = wd;
    bus_z.RdEn0 = re0; bus_z.RdAddr0 = ra0; bus_z.RdEn1 = re1; bus_z.RdAddr1 = ra1;
    nleft = m_left;
    if (rst) begin
      nleft = DEPTH;
      for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
    end else if (m_left > 0) begin
      nleft = m_left - 1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (re0) begin
          e.cyc = cyc + 1; e.data = exp_read(d, ra0, we, clr, wa, wd);
          exp_q[d*2].push_back(e);
        end
        if (re1) begin
          e.cyc = cyc + 1; e.data = exp_read(d, ra1, we, clr, wa, wd);
          exp_q[d*2+1].push_back(e);
        end
      end
      if (clr) begin
        nleft = DEPTH;
        for (int d = 0; d < 2; d++) for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
      end else if (we) begin
        m_mem[0][wa] = wd;
        if (wa != '0) m_mem[1][wa] = wd;
      end
    end
    @(posedge Clk);
    cyc++;
    m_left  = nleft;
    m_busy  = (nleft > 0);
    started = 1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic mon_port(input int qi, input logic vld, input logic [DW-1:0] dat);
    exp_t e;
    if (vld) begin
      if (exp_q[qi].size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid q%0d cyc=%0d got=1 exp=0", qi, cyc);
      end else begin
        e = exp_q[qi].pop_front();
        check($sformatf("rd_cycle_q%0d", qi), cyc, e.cyc);
        check($sformatf("rd_data_q%0d", qi), dat, e.data);
      end
    end else begin
      check($sformatf("idle_data_q%0d", qi), dat, '0);
      if (exp_q[qi].size() > 0) begin
        e = exp_q[qi][0];
        if (e.cyc <= cyc) begin
          checks++; failures++;
          $display("FAIL missing_valid q%0d cyc=%0d got=0 exp=1 data=%h", qi, cyc, e.data);
          void'(exp_q[qi].pop_front());
        end
      end
    end
  endtask

  always @(negedge Clk) begin
    if (started) begin
      check("busy_a", bus_a.Busy, m_busy);
      check("busy_z", bus_z.Busy, m_busy);
      mon_port(0, bus_a.RdValid0, bus_a.RdData0);
      mon_port(1, bus_a.RdValid1, bus_a.RdData1);
      mon_port(2, bus_z.RdValid0, bus_z.RdData0);
      mon_port(3, bus_z.RdValid1, bus_z.RdData1);
    end
  end

  initial begin
    logic          rst, clr, we, re0, re1;
    logic [AW-1:0] wa, ra0, ra1;
    logic [DW-1:0] wd;
    Rst = 1'b1;
    // Reset, full sweep, then every address must read back zero.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    repeat (DEPTH) idle();
    for (int a = 0; a < DEPTH; a++)
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(DEPTH - 1 - a));
    idle();
    // Write then dual read of the same address.
    step(1'b0, 1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 1'b1, 4'd5);
    idle();
    // Same-cycle write/read collision.
    step(1'b0, 1'b0, 1'b1, 4'd3, 32'h11, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 4'd3, 32'h22, 1'b1, 4'd3, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3, 1'b1, 4'd3);
    // Clr drops the coincident write; requests during the sweep are ignored.
    step(1'b0, 1'b0, 1'b1, 4'd7, 32'hA5, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 4'd7, 32'h5A, 1'b1, 4'd7, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 4'd7, 32'h5A, 1'b1, 4'd7, 1'b1, 4'd7);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 1'b1, 4'd5);
    // Reset in the middle of a sweep restarts it.
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    repeat (8) idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 4'd1, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, 1'b1, 4'd9, 32'h99, 1'b1, 4'd9, 1'b1, 4'd2);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd9, 1'b1, 4'd2);
    // Register 0 behaviour (hardwired zero on dut_z only).
    step(1'b0, 1'b0, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd0, 1'b1, 4'd0);
    // Randomized traffic with occasional Clr and Rst.
    for (int i = 0; i < 600; i++) begin
      rst = 1'($urandom_range(0, 249) == 0);
      clr = 1'($urandom_range(0, 49) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, DEPTH - 1));
      wd  = $urandom;
      re0 = 1'($urandom_range(0, 3) != 0);
      re1 = 1'($urandom_range(0, 3) != 0);
      ra0 = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : AW'($urandom_range(0, DEPTH - 1));
      step(rst, clr, we, wa, wd, re0, ra0, re1, ra1);
    end
    repeat (3) idle();
    for (int q = 0; q < 4; q++)
      check($sformatf("drain_q%0d", q), exp_q[q].size(), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
